dk_sound_mixer: RTL
===================

Name: dk_sound_mixer

Overview:
- Final mixing stage downstream of the per-voice discrete sound circuits (walk, jump, stomp, etc.); consumes each voice's signed 16-bit sample.
- Applies a per-voice gain, sums the weighted samples and saturates the result to one signed 16-bit sample per audio_clk_en tick for the audio output path.
- Uses one time-multiplexed multiply-accumulate unit, one voice per clk cycle, instead of NUM_INPUTS parallel multipliers.

Parameters:
- NUM_INPUTS, 4, number of voices mixed (1..16).
- GAIN_FRAC_BITS, 6, fractional bits of the unsigned 8-bit gain; 64 = unity, 255 ≈ 3.98.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- audio_clk_en  in  1  one-cycle sample strobe; starts one mix.
- inputs  in  NUM_INPUTS*16  packed signed voice samples; voice i = bits [16*i+15:16*i].
- gains  in  NUM_INPUTS*8  packed unsigned gains; voice i = bits [8*i+7:8*i].
- mute  in  1  when high, the next produced sample is forced to 0.
- out  out  16  signed mixed sample, held between updates.
- out_valid  out  1  one-cycle pulse when out updates.
- overrun  out  1  sticky flag; audio_clk_en arrived while a mix was in progress.

Behaviour:
- Reset: out=0, out_valid=0, overrun=0, accumulator=0, state=IDLE, voice index=0. Reset overrides everything in the same cycle, including a mid-mix reset; the partial mix is discarded and out is not updated.
- States: IDLE -> ACCUM -> FINISH -> IDLE.
- IDLE: when audio_clk_en=1, snapshot all inputs, all gains and mute into holding registers, clear the accumulator, set index=0 and go to ACCUM. Voice values that change after this edge do not affect this mix.
- ACCUM: each cycle, accumulator += sample[index] * gain[index].
  - Product is signed 16 x unsigned 8 -> signed 25 bits; the gain is zero-extended before the signed multiply.
  - Accumulator width is 25 + clog2(NUM_INPUTS) + 1 bits; the accumulator never wraps.
  - index increments each cycle. After the cycle with index = NUM_INPUTS-1, go to FINISH.
- FINISH: compute result = accumulator >>> GAIN_FRAC_BITS (arithmetic shift, i.e. floor rounding toward -inf).
  - Saturate: result > 32767 -> 32767; result < -32768 -> -32768.
  - out <= 0 if the captured mute=1, else the saturated result.
  - out_valid=1 for exactly this one cycle, then go to IDLE.
- Latency: out and out_valid update on the clock edge NUM_INPUTS+1 edges after the edge that sampled audio_clk_en (5 edges for the default).
- audio_clk_en=1 in ACCUM or FINISH: the strobe is ignored (no restart) and overrun is set to 1; overrun stays 1 until reset.
- audio_clk_en=1 in the same cycle FINISH returns to IDLE: the strobe counts as busy, so overrun is set.
- Integration constraint: the CLOCK_RATE/SAMPLE_RATE ratio must be at least NUM_INPUTS+2; the 1 MHz/48 kHz ratio of 20 satisfies this.
- out_valid is never high in two consecutive cycles.

Test Plan:
- Unity mix: gains all 64; inputs 1000, 2000, -500, 0; one strobe -> after 5 edges out=2500, out_valid high for 1 cycle, overrun=0.
- Positive saturation: all inputs 30000, gains 64 -> out=32767. Negative saturation: all inputs -30000 -> out=-32768.
- Fractional gain and rounding: voice0 = -7 with gain 32, other gains 0 -> product -224, -224>>>6 = -4 -> out=-4. Voice0 = 100 with gain 255 -> 25500>>>6 = 398 -> out=398.
- Snapshot and mute: change inputs on the cycle after the strobe -> out reflects the old values. Strobe with mute=1 -> out=0 and out_valid still pulses.
- Overrun: a second strobe 2 cycles after the first -> the first mix completes unchanged, no second out_valid, overrun=1 and sticky across later clean strobes.
- Reset mid-mix: assert reset 2 cycles after a strobe -> out=0, out_valid never pulses, overrun=0. A following strobe yields the correct sample 5 edges later.

Source files
------------

// File: rtl/dk_sound_mixer.sv
// Final mixing stage for the discrete sound voices: per-voice gain, summed on one
// time-multiplexed MAC, then arithmetic-shifted and saturated to a signed 16-bit sample.
module dk_sound_mixer #(
    parameter int unsigned NUM_INPUTS     = 4,
    parameter int unsigned GAIN_FRAC_BITS = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     audio_clk_en,
    input  logic [NUM_INPUTS*16-1:0] inputs,
    input  logic [NUM_INPUTS*8-1:0]  gains,
    input  logic                     mute,
    output logic [15:0]              out,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int unsigned ACC_W = 25 + $clog2(NUM_INPUTS) + 1;
    localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [15:0]       held_samp [NUM_INPUTS];
    logic [7:0]               held_gain [NUM_INPUTS];
    logic                     held_mute;

    logic signed [24:0]       sample_ext;
    logic signed [24:0]       gain_ext;
    logic signed [24:0]       product;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [15:0]       sat;

    // Gain is zero-extended so the signed multiply never treats gains >= 128 as negative.
    always_comb begin
        sample_ext = {{9{held_samp[idx][15]}}, held_samp[idx]};
        gain_ext   = {17'b0, held_gain[idx]};
        product    = sample_ext * gain_ext;
        shifted    = acc >>> GAIN_FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sat = 16'sh7fff;
        end else if (shifted < SAT_MIN) begin
            sat = 16'sh8000;
        end else begin
            sat = shifted[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            held_mute <= 1'b0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                held_samp[i] <= '0;
                held_gain[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (audio_clk_en) begin
                        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                            held_samp[i] <= inputs[16*i +: 16];
                            held_gain[i] <= gains[8*i +: 8];
                        end
                        held_mute <= mute;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + {{(ACC_W-25){product[24]}}, product};
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                    if (audio_clk_en) begin
                        overrun <= 1'b1;
                    end
                end
                FINISH: begin
                    out       <= held_mute ? '0 : sat;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    if (audio_clk_en) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
